burst_axi_master: RTL and testbench
===================================

# burst_axi_master

Parametrised successor of the single-beat AXI4 master: it turns one user request into an AXI4 INCR burst of 1 to MAX_BEATS beats on a DATA_W-bit bus. Write data is streamed in and read data is streamed out, one beat at a time. Each request is checked for legality before any AXI traffic starts. It sits between a core-side controller (DMA or register sequencer) and the AXI interconnect, and replaces the single-beat master wherever bursts are needed.

## Interface
- ADDR_W, 32, address width
- DATA_W, 64, AXI data width; legal values 32, 64 and 128
- ID_W, 1, AXI ID width
- MAX_BEATS, 16, largest burst length; 1 to 256
- i_clk  in  1  clock; all logic samples on the rising edge
- i_rst_n  in  1  reset; asynchronous, active-low
- i_rw  in  2  request: 00 idle, 01 write, 10 read, 11 reserved (ignored)
- i_addr  in  ADDR_W  start address
- i_size  in  3  beat size, log2 of the byte count
- i_len  in  8  number of beats minus 1
- i_wdata  in  DATA_W  write beat data, lane-aligned as on AXI
- i_wvalid  in  1  write beat available
- o_wready  out  1  write beat consumed this cycle
- o_rdata  out  DATA_W  registered read beat
- o_rvalid  out  1  one-cycle pulse per read beat
- o_wait  out  1  transfer active
- i_clear  in  1  clears o_done, o_error and o_invalid
- o_done, o_error, o_invalid  out  1 each  sticky status flags
- m_axi_aw*, m_axi_w*, m_axi_b*, m_axi_ar*, m_axi_r*: full AXI4 master port
  - id fields are ID_W bits wide
  - data is DATA_W bits wide; strobe is DATA_W/8 bits wide

## Operation
- States: IDLE, AW, W, B, AR, R.
- IDLE accepts a request when i_rw is 01 or 10.
  - Accepting a request clears all three status flags.
  - o_wait goes high the next cycle and stays high until the transfer completes.
- Invalid request: o_invalid is set and the block returns to IDLE with no AXI activity. A request is invalid if any of these hold:
  - i_size > log2(DATA_W/8);
  - i_addr is not aligned to 1<<i_size;
  - i_len >= MAX_BEATS;
  - the burst crosses a 4 KB boundary, i.e. (addr & 0xFFF) + ((len+1)<<size) > 4096.
- Write path: AW → W → B.
  - AW holds awvalid until awready. awaddr = i_addr, awlen = i_len, awsize = i_size.
  - W starts after the AW handshake. m_axi_wvalid = i_wvalid and o_wready = m_axi_wready, both only while in W.
  - Strobe for beat k: ((1<<(1<<size))-1) << (addr_k mod DATA_W/8), where addr_k = addr + k·(1<<size).
  - wlast is asserted on beat i_len.
- Write response: B holds bready high until bvalid. bresp != 00 sets o_error. o_done is set in all cases.
- Read path: AR → R.
  - AR mirrors AW.
  - R holds rready high for the whole state; there is no backpressure to the user.
  - Each beat is registered into o_rdata and o_rvalid pulses for it.
  - Any rresp != 00 sets o_error; the burst still runs to completion.
  - Leaving R is triggered by rlast. rlast on a beat other than i_len, or no rlast on beat i_len, sets o_error.
- Fixed AXI fields:
  - burst = 01 (INCR), cache = 0011, prot = 000;
  - lock = 0, qos = 0, region = 0, id = 0.
- i_clear clears the flags in any state. If i_clear arrives in the same cycle as a request acceptance, the flags end up clear. If it arrives in the same cycle as a flag being set, the set wins.
- i_rw is ignored whenever the state is not IDLE.

## Timing
- Reset (asynchronous assert, synchronous deassert):
  - state goes to IDLE;
  - all valids, readys, o_wait, o_rvalid and the flags go to 0;
  - o_rdata and the address/len/size registers go to 0.
- Assertion of i_rst_n low mid-burst drops every valid immediately. There is no recovery of the interrupted transfer.
- Latency:
  - accept in cycle 0 → awvalid/arvalid high in cycle 1, registered;
  - invalid request → o_invalid high in cycle 1 and o_wait stays 0.
- A W beat transfers in any cycle where i_wvalid and wready are both high while in W. The beat counter increments on each transfer.
- o_rvalid and o_rdata appear one cycle after the R handshake.
- Completion: o_done rises and o_wait falls in the cycle after the B handshake (write) or the rlast handshake (read).
- The next request can be accepted in that same cycle.
- Minimum write of N beats with zero-wait slaves: 1 (AW) + N (W) + 1 (B) + 1 cycles.

## Test plan
- DATA_W=64, write addr 0x1000, size 3, len 3, zero-wait slave → 4 W beats, all strobes 0xFF, wlast on beat 3 only, o_done set, o_error 0.
- Write addr 0x1002, size 1, len 2 → strobes 0x0C, 0x30, 0xC0.
- Read len 7 with rresp 10 on beat 4 → 8 o_rvalid pulses, o_error 1, o_done 1.
- Invalid requests, each with no AXI valid ever asserted:
  - addr 0x0FF8, size 3, len 1 → o_invalid 1 (crosses 4 KB);
  - addr 0x1001, size 1 → o_invalid 1 (misaligned).
- Read len 3 with the slave asserting rlast on beat 1 → o_error 1, state back to IDLE. Repeat with random ready/valid stalls and check beat-count integrity.
- i_rst_n pulsed low during W beat 2 → all valids 0 in the same cycle. After release, the next read completes normally.

Source files
------------

// File: rtl/burst_axi_master.sv
// AXI4 INCR burst master: one user request becomes a legality-checked burst of
// 1..MAX_BEATS beats, with write data streamed in and read data streamed out.
module burst_axi_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 64,
  parameter int ID_W      = 1,
  parameter int MAX_BEATS = 16
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_rw,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic [2:0]          i_size,
  input  logic [7:0]          i_len,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic                i_wvalid,
  output logic                o_wready,
  output logic [DATA_W-1:0]   o_rdata,
  output logic                o_rvalid,
  output logic                o_wait,
  input  logic                i_clear,
  output logic                o_done,
  output logic                o_error,
  output logic                o_invalid,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic [3:0]          m_axi_awregion,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  output logic [3:0]          m_axi_arregion,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);
  localparam int STRB_W   = DATA_W / 8;
  localparam int OFF_W    = $clog2(STRB_W);
  localparam int SIZE_MAX = $clog2(STRB_W);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q;
  logic [7:0]         len_q;
  logic [2:0]         size_q;
  logic [7:0]         beat_q;
  logic [OFF_W-1:0]   off_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               rvalid_q, done_q, error_q, invalid_q;

  logic        accept, is_write, req_bad;
  logic        bad_size, bad_align, bad_len, bad_4k;
  logic [16:0] span;
  logic        w_hs, r_hs, b_hs, last_beat;
  logic        done_set, err_set, clr;
  logic [7:0]  step_bytes;
  logic [STRB_W-1:0] lane_mask;
  logic        unused_ids;

  assign accept   = (state_q == S_IDLE) && ((i_rw == 2'b01) || (i_rw == 2'b10));
  assign is_write = (i_rw == 2'b01);

  assign bad_size  = i_size > 3'(SIZE_MAX);
  assign bad_align = (i_addr & ((ADDR_W'(1) << i_size) - ADDR_W'(1))) != '0;
  assign bad_len   = {1'b0, i_len} >= 9'(MAX_BEATS);
  assign span      = 17'({1'b0, i_len} + 9'd1) << i_size;
  assign bad_4k    = ({5'd0, i_addr[11:0]} + span) > 17'd4096;
  assign req_bad   = bad_size | bad_align | bad_len | bad_4k;

  assign w_hs      = m_axi_wvalid & m_axi_wready;
  assign r_hs      = m_axi_rvalid & m_axi_rready;
  assign b_hs      = m_axi_bvalid & m_axi_bready;
  assign last_beat = (beat_q == len_q);

  // Lane offset advances by the beat size; alignment is guaranteed, so it wraps cleanly.
  assign step_bytes = 8'd1 << size_q;
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < STRB_W; i++)
      if (i < int'(step_bytes)) lane_mask[i] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    o_wready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    o_wait        = 1'b1;
    unique case (state_q)
      S_IDLE: begin
        o_wait = 1'b0;
        if (accept && !req_bad) state_d = is_write ? S_AW : S_AR;
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = S_W;
      end
      S_W: begin
        m_axi_wvalid = i_wvalid;
        o_wready     = m_axi_wready;
        if (w_hs && last_beat) state_d = S_B;
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) state_d = S_IDLE;
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = S_R;
      end
      S_R: begin
        m_axi_rready = 1'b1;
        if (m_axi_rvalid && m_axi_rlast) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Set beats clear: a flag raised in the same cycle as i_clear survives.
  assign clr      = i_clear | accept;
  assign done_set = b_hs | (r_hs & m_axi_rlast);
  assign err_set  = (b_hs & (m_axi_bresp != 2'b00)) |
                    (r_hs & ((m_axi_rresp != 2'b00) | (m_axi_rlast != last_beat)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      beat_q    <= '0;
      off_q     <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      if (accept && !req_bad) begin
        addr_q <= i_addr;
        len_q  <= i_len;
        size_q <= i_size;
        beat_q <= '0;
        off_q  <= i_addr[OFF_W-1:0];
      end
      if (w_hs) begin
        beat_q <= beat_q + 8'd1;
        off_q  <= off_q + step_bytes[OFF_W-1:0];
      end
      if (r_hs) begin
        beat_q   <= beat_q + 8'd1;
        rdata_q  <= m_axi_rdata;
        rvalid_q <= 1'b1;
      end
      done_q    <= done_set | (done_q & ~clr);
      error_q   <= err_set | (error_q & ~clr);
      invalid_q <= (accept & req_bad) | (invalid_q & ~clr);
    end
  end

  assign o_rdata   = rdata_q;
  assign o_rvalid  = rvalid_q;
  assign o_done    = done_q;
  assign o_error   = error_q;
  assign o_invalid = invalid_q;

  assign m_axi_awid     = '0;
  assign m_axi_awaddr   = addr_q;
  assign m_axi_awlen    = len_q;
  assign m_axi_awsize   = size_q;
  assign m_axi_awburst  = 2'b01;
  assign m_axi_awlock   = 1'b0;
  assign m_axi_awcache  = 4'b0011;
  assign m_axi_awprot   = 3'b000;
  assign m_axi_awqos    = 4'b0000;
  assign m_axi_awregion = 4'b0000;

  assign m_axi_wdata = i_wdata;
  assign m_axi_wstrb = lane_mask << off_q;
  assign m_axi_wlast = last_beat;

  assign m_axi_arid     = '0;
  assign m_axi_araddr   = addr_q;
  assign m_axi_arlen    = len_q;
  assign m_axi_arsize   = size_q;
  assign m_axi_arburst  = 2'b01;
  assign m_axi_arlock   = 1'b0;
  assign m_axi_arcache  = 4'b0011;
  assign m_axi_arprot   = 3'b000;
  assign m_axi_arqos    = 4'b0000;
  assign m_axi_arregion = 4'b0000;

  assign unused_ids = ^{m_axi_bid, m_axi_rid};
endmodule

// File: tb/tb_burst_axi_master.sv
// Directed bench for burst_axi_master: a reactive AXI slave plus scoreboards for
// write beats (pushed at request time) and read beats (pushed at the R handshake).
module tb_burst_axi_master;
  localparam int ADDR_W = 32, DATA_W = 64, ID_W = 1, MAX_BEATS = 16, STRB_W = 8;

  logic i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  logic i_rst_n, i_clear, i_wvalid, o_wready, o_rvalid, o_wait, o_done, o_error, o_invalid;
  logic [1:0] i_rw;
  logic [ADDR_W-1:0] i_addr;
  logic [2:0] i_size;
  logic [7:0] i_len;
  logic [DATA_W-1:0] i_wdata, o_rdata;
  logic [ID_W-1:0] awid, arid, bid, rid;
  logic [ADDR_W-1:0] awaddr, araddr;
  logic [7:0] awlen, arlen;
  logic [2:0] awsize, arsize, awprot, arprot;
  logic [1:0] awburst, arburst, bresp, rresp;
  logic awlock, arlock, awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rlast, rvalid, rready;
  logic [3:0] awcache, arcache, awqos, arqos, awregion, arregion;
  logic [DATA_W-1:0] wdata, rdata;
  logic [STRB_W-1:0] wstrb;

  burst_axi_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .MAX_BEATS(MAX_BEATS)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_rw(i_rw), .i_addr(i_addr), .i_size(i_size),
    .i_len(i_len), .i_wdata(i_wdata), .i_wvalid(i_wvalid), .o_wready(o_wready),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_wait(o_wait), .i_clear(i_clear),
    .o_done(o_done), .o_error(o_error), .o_invalid(o_invalid),
    .m_axi_awid(awid), .m_axi_awaddr(awaddr), .m_axi_awlen(awlen), .m_axi_awsize(awsize),
    .m_axi_awburst(awburst), .m_axi_awlock(awlock), .m_axi_awcache(awcache),
    .m_axi_awprot(awprot), .m_axi_awqos(awqos), .m_axi_awregion(awregion),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wlast(wlast),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bid(bid), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_arid(arid), .m_axi_araddr(araddr), .m_axi_arlen(arlen), .m_axi_arsize(arsize),
    .m_axi_arburst(arburst), .m_axi_arlock(arlock), .m_axi_arcache(arcache),
    .m_axi_arprot(arprot), .m_axi_arqos(arqos), .m_axi_arregion(arregion),
    .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rid(rid), .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rlast(rlast),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready));

  typedef struct packed {logic [63:0] data; logic [7:0] strb; logic last;} wexp_t;
  wexp_t       wq[$];
  logic [63:0] rq[$];

  int n_tests = 0, n_fail = 0;
  int w_hs_cnt = 0, r_pulse_cnt = 0, valid_seen = 0, src_beat = 0;
  bit stall = 0;
  logic [1:0] bresp_cfg = 2'b00;
  int rerr_beat = -1, rlast_at = -1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wpat(input int k);
    return {32'hC0DE0000 + 32'(k), 32'h0BEEF000 ^ 32'(k)};
  endfunction

  function automatic logic [7:0] strb_model(input int a, input int sz, input int k);
    int off, m;
    off = (a + k * (1 << sz)) % STRB_W;
    m   = (1 << (1 << sz)) - 1;
    return 8'((m << off) & 255);
  endfunction

  task automatic push_write(input int a, input int sz, input int ln);
    for (int k = 0; k <= ln; k++) wq.push_back('{wpat(k), strb_model(a, sz, k), k == ln});
  endtask

  // Slave responder and scoreboard monitor: observe at negedge, drive at posedge+1.
  initial begin : slave
    bit aw_hs, w_hs, w_last, b_hs, ar_hs, r_hs, r_hs_prev, r_active, b_pend;
    int r_beat, r_last_idx, ar_len;
    wexp_t e;
    r_hs_prev = 0; r_active = 0; b_pend = 0; r_beat = 0; r_last_idx = 0; ar_len = 0;
    awready = 1; arready = 1; wready = 1; bvalid = 0; bresp = 0; bid = '0;
    rvalid = 0; rdata = '0; rresp = 0; rlast = 0; rid = '0;
    i_wvalid = 1; i_wdata = wpat(0);
    forever begin
      @(negedge i_clk);
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      w_last = wlast;
      b_hs  = bvalid && bready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      if (ar_hs) ar_len = int'(arlen);
      if (awvalid || wvalid || arvalid) valid_seen++;
      if (r_hs_prev || o_rvalid) chk("rvalid_latency", o_rvalid, r_hs_prev);
      if (o_rvalid) begin
        r_pulse_cnt++;
        chk("rq_nonempty", rq.size() > 0, 1);
        if (rq.size() > 0) chk("rdata", o_rdata, rq.pop_front());
      end
      if (w_hs) begin
        w_hs_cnt++;
        chk("wq_nonempty", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          e = wq.pop_front();
          chk("wstrb", wstrb, e.strb);
          chk("wlast", wlast, e.last);
          chk("wdata", wdata, e.data);
        end
      end
      if (r_hs) rq.push_back(rdata);
      r_hs_prev = r_hs;
      @(posedge i_clk); #1;
      if (!i_rst_n) begin
        r_active = 0; b_pend = 0; bvalid = 0; rvalid = 0; rlast = 0; r_hs_prev = 0;
        continue;
      end
      awready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      arready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      wready  = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_hs) src_beat++;
      i_wdata  = wpat(src_beat);
      i_wvalid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (w_hs && w_last) b_pend = 1;
      if (b_hs) bvalid = 0;
      if (b_pend && !bvalid && (!stall || $urandom_range(0, 1) == 1)) begin
        bvalid = 1; bresp = bresp_cfg; b_pend = 0;
      end
      if (ar_hs) begin
        r_active = 1; r_beat = 0;
        r_last_idx = (rlast_at >= 0) ? rlast_at : ar_len;
      end
      if (r_hs) begin
        if (rlast) r_active = 0;
        r_beat++;
        rvalid = 0;
      end
      if (r_active && !rvalid && (!stall || $urandom_range(0, 1) == 1)) begin
        rvalid = 1;
        rdata  = {$urandom, $urandom};
        rresp  = (r_beat == rerr_beat) ? 2'b10 : 2'b00;
        rlast  = (r_beat == r_last_idx);
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic req(input logic [1:0] rw, input logic [31:0] a, input logic [2:0] sz,
                     input logic [7:0] ln);
    @(posedge i_clk); #2;
    i_rw = rw; i_addr = a; i_size = sz; i_len = ln;
    @(posedge i_clk); #2;
    i_rw = 2'b00;
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (o_wait && cycles < budget) begin
      @(posedge i_clk); #2;
      cycles++;
    end
    chk("idle_timeout", o_wait, 1'b0);
  endtask

  task automatic settle_rvalid();
    @(negedge i_clk); #1;
  endtask

  initial begin : main
    int cyc, base, vs;
    i_rst_n = 0; i_rw = 0; i_addr = 0; i_size = 0; i_len = 0; i_clear = 0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk); i_rst_n = 1;
    @(posedge i_clk); #2;
    chk("rst_wait", o_wait, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_invalid", o_invalid, 0);
    chk("rst_rvalid", o_rvalid, 0);
    chk("rst_rdata", o_rdata, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awaddr", awaddr, 0);

    // 4-beat full-width write, zero-wait slave
    src_beat = 0; base = w_hs_cnt;
    push_write(32'h1000, 3, 3);
    req(2'b01, 32'h1000, 3'd3, 8'd3);
    chk("wr1_wait", o_wait, 1);
    chk("wr1_awvalid", awvalid, 1);
    chk("wr1_awaddr", awaddr, 32'h1000);
    chk("wr1_awlen", awlen, 3);
    chk("wr1_awsize", awsize, 3);
    chk("wr1_awburst", awburst, 2'b01);
    chk("wr1_awcache", awcache, 4'b0011);
    chk("wr1_awfixed", {awid, awlock, awprot, awqos, awregion}, 0);
    wait_idle(50, cyc);
    chk("wr1_cycles", cyc + 1, 7);
    chk("wr1_beats", w_hs_cnt - base, 4);
    chk("wr1_done", o_done, 1);
    chk("wr1_error", o_error, 0);
    chk("wr1_wq_empty", wq.size(), 0);

    // narrow beats at a lane offset
    src_beat = 0;
    wq.push_back('{wpat(0), 8'h0C, 1'b0});
    wq.push_back('{wpat(1), 8'h30, 1'b0});
    wq.push_back('{wpat(2), 8'hC0, 1'b1});
    req(2'b01, 32'h1002, 3'd1, 8'd2);
    wait_idle(50, cyc);
    chk("wr2_done", o_done, 1);
    chk("wr2_wq_empty", wq.size(), 0);

    // slave error response on write, then clear
    src_beat = 0; bresp_cfg = 2'b10;
    push_write(32'h2000, 2, 1);
    req(2'b01, 32'h2000, 3'd2, 8'd1);
    wait_idle(50, cyc);
    chk("wr3_error", o_error, 1);
    chk("wr3_done", o_done, 1);
    bresp_cfg = 2'b00;
    @(posedge i_clk); #2; i_clear = 1;
    @(posedge i_clk); #2; i_clear = 0;
    chk("clear_done", o_done, 0);
    chk("clear_error", o_error, 0);

    // 8-beat read with an error response mid-burst
    rerr_beat = 4; base = r_pulse_cnt;
    req(2'b10, 32'h3000, 3'd3, 8'd7);
    chk("rd1_arvalid", arvalid, 1);
    chk("rd1_araddr", araddr, 32'h3000);
    chk("rd1_arlen", arlen, 7);
    chk("rd1_arburst", arburst, 2'b01);
    wait_idle(60, cyc);
    settle_rvalid();
    chk("rd1_pulses", r_pulse_cnt - base, 8);
    chk("rd1_error", o_error, 1);
    chk("rd1_done", o_done, 1);
    chk("rd1_rq_empty", rq.size(), 0);
    rerr_beat = -1;

    // illegal requests produce no AXI traffic
    vs = valid_seen;
    req(2'b01, 32'h0FF8, 3'd3, 8'd1);
    chk("inv_4k", o_invalid, 1);
    chk("inv_4k_wait", o_wait, 0);
    chk("inv_4k_done_cleared", o_done, 0);
    req(2'b10, 32'h1001, 3'd1, 8'd0);
    chk("inv_align", o_invalid, 1);
    req(2'b10, 32'h1000, 3'd2, 8'd16);
    chk("inv_len", o_invalid, 1);
    req(2'b01, 32'h1000, 3'd4, 8'd0);
    chk("inv_size", o_invalid, 1);
    repeat (3) @(posedge i_clk);
    #2 chk("inv_no_valid", valid_seen - vs, 0);

    // burst ending exactly at the 4 KB boundary is legal; reserved rw is ignored
    base = r_pulse_cnt;
    req(2'b10, 32'h0FF0, 3'd3, 8'd1);
    chk("edge4k_invalid", o_invalid, 0);
    chk("edge4k_wait", o_wait, 1);
    wait_idle(50, cyc);
    settle_rvalid();
    chk("edge4k_pulses", r_pulse_cnt - base, 2);
    vs = valid_seen;
    req(2'b11, 32'h1000, 3'd3, 8'd0);
    chk("rw11_wait", o_wait, 0);
    chk("rw11_invalid", o_invalid, 0);
    repeat (2) @(posedge i_clk);
    #2 chk("rw11_no_valid", valid_seen - vs, 0);

    // early rlast
    rlast_at = 1; base = r_pulse_cnt;
    req(2'b10, 32'h3100, 3'd3, 8'd3);
    wait_idle(50, cyc);
    settle_rvalid();
    chk("early_rlast_error", o_error, 1);
    chk("early_rlast_pulses", r_pulse_cnt - base, 2);
    chk("early_rlast_idle", o_wait, 0);
    rlast_at = -1;

    // random stalls on every channel
    stall = 1; src_beat = 0; base = w_hs_cnt;
    push_write(32'h4004, 2, 5);
    req(2'b01, 32'h4004, 3'd2, 8'd5);
    wait_idle(400, cyc);
    chk("stall_wr_beats", w_hs_cnt - base, 6);
    chk("stall_wr_error", o_error, 0);
    chk("stall_wr_done", o_done, 1);
    base = r_pulse_cnt;
    req(2'b10, 32'h5000, 3'd3, 8'd5);
    wait_idle(400, cyc);
    settle_rvalid();
    chk("stall_rd_pulses", r_pulse_cnt - base, 6);
    chk("stall_rd_error", o_error, 0);
    chk("stall_rd_rq_empty", rq.size(), 0);
    stall = 0;

    // reset during W beat 2, then a clean read
    src_beat = 0; base = w_hs_cnt;
    push_write(32'h6000, 3, 5);
    req(2'b01, 32'h6000, 3'd3, 8'd5);
    cyc = 0;
    while ((w_hs_cnt - base) < 2 && cyc < 50) begin
      @(posedge i_clk); #2;
      cyc++;
    end
    chk("rst_mid_reach_beat2", w_hs_cnt - base, 2);
    chk("rst_mid_wvalid_before", wvalid, 1);
    #1 i_rst_n = 0;
    #1;
    chk("rst_mid_valids", {awvalid, wvalid, arvalid, bready, rready, o_wready}, 0);
    chk("rst_mid_wait", o_wait, 0);
    repeat (2) @(posedge i_clk);
    wq.delete(); rq.delete();
    @(negedge i_clk); i_rst_n = 1;
    base = r_pulse_cnt;
    req(2'b10, 32'h7000, 3'd3, 8'd3);
    wait_idle(50, cyc);
    settle_rvalid();
    chk("post_rst_pulses", r_pulse_cnt - base, 4);
    chk("post_rst_done", o_done, 1);
    chk("post_rst_error", o_error, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
